// File: rtl/mux_4to1_pkg.sv
// Shared constants and select-rotation helper for the 4-way rotating selector bank.
package mux_4to1_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_IN = 4;

    // The 2-bit add wraps naturally, which gives the mod-4 rotation with no carry kept.
    function automatic logic [SEL_W-1:0] rot_idx(input logic [SEL_W-1:0] s, input int unsigned k);
        logic [SEL_W-1:0] kk;
        kk = k[SEL_W-1:0];
        return s + kk;
    endfunction

endpackage

// File: rtl/mux_4to1_mux4_comb.sv
// Combinational DATA_W-wide 4:1 multiplexer with a 2-bit select.
module mux4_comb
    import mux_4to1_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [SEL_W-1:0]               sel,
    input  logic [NUM_IN-1:0][DATA_W-1:0]  data,
    output logic [DATA_W-1:0]              out
);

    assign out = data[sel];

endmodule

// File: rtl/mux_4to1.sv
// Registered selector bank: E1 is the plain 4:1 mux of A..D, E2..E4 successive rotations.
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              x,
    input  logic              y,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] C,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] E1,
    output logic [DATA_W-1:0] E2,
    output logic [DATA_W-1:0] E3,
    output logic [DATA_W-1:0] E4
);

    logic [SEL_W-1:0]              s;
    logic [NUM_IN-1:0][DATA_W-1:0] data;
    logic [NUM_IN-1:0][DATA_W-1:0] e_next;
    logic [NUM_IN-1:0][DATA_W-1:0] e_q;

    assign s    = {x, y};
    assign data = {D, C, B, A};

    // Output k reads input (s + k) mod 4, so the four outputs form a barrel rotation.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_mux
        logic [SEL_W-1:0] sel;
        assign sel = rot_idx(s, k);
        mux4_comb #(.DATA_W(DATA_W)) u_mux (
            .sel  (sel),
            .data (data),
            .out  (e_next[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            e_q <= '0;
        else if (en)
            e_q <= e_next;
    end

    assign E1 = e_q[0];
    assign E2 = e_q[1];
    assign E3 = e_q[2];
    assign E4 = e_q[3];

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: directed cases, exhaustive sweep and random run against a rotation model.
module tb_mux_4to1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       x     = 1'b0;
    logic       y     = 1'b0;
    logic [0:0] A = '0, B = '0, C = '0, D = '0;
    logic [0:0] E1, E2, E3, E4;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mdl_e  = '0;   // expected {E4,E3,E2,E1}
    logic [3:0] mdl_in = '0;   // last loaded {D,C,B,A}

    mux_4to1 #(.DATA_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y),
        .A(A), .B(B), .C(C), .D(D),
        .E1(E1), .E2(E2), .E3(E3), .E4(E4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, act, exp, $time);
        end
    endtask

    // Output k carries data index (s + k) mod 4.
    function automatic logic [3:0] model(input int s, input logic [3:0] din);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = din[(s + k) % 4];
        return r;
    endfunction

    function automatic logic [3:0] outs();
        return {E4, E3, E2, E1};
    endfunction

    // Drive at negedge, let one posedge load, then check just after it.
    task automatic apply(input string tag, input int s, input logic [3:0] din, input logic e);
        logic [3:0] o;
        @(negedge clk);
        x = s[1]; y = s[0];
        A = din[0]; B = din[1]; C = din[2]; D = din[3];
        en = e;
        @(posedge clk);
        if (rst_n && e) begin
            mdl_e  = model(s, din);
            mdl_in = din;
        end
        #1;
        o = outs();
        chk(tag, o, mdl_e);
        chk("perm", 4'($countones(o)), 4'($countones(mdl_in)));
    endtask

    initial begin
        // Reset with all inputs high and enable on.
        A = 1; B = 1; C = 1; D = 1; en = 1;
        #2 rst_n = 1'b0;
        #1 chk("rst_async", outs(), 4'b0000);
        repeat (2) @(posedge clk);
        #1 chk("rst_hold", outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep over {x,y,A,B,C,D}.
        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            apply("sweep", int'(v[5:4]), {v[0], v[1], v[2], v[3]}, 1'b1);
        end

        // x=1,y=0, only C high: E1 takes C.
        apply("example", 2, 4'b0100, 1'b1);
        chk("example_k", outs(), 4'b0001);

        // Rotation with only A high.
        apply("rot_s3", 3, 4'b0001, 1'b1);
        chk("rot_s3_k", outs(), 4'b0010);
        apply("rot_s0", 0, 4'b0001, 1'b1);
        chk("rot_s0_k", outs(), 4'b0001);

        // Hold with en low.
        apply("hold_load", 0, 4'b0001, 1'b1);
        apply("hold_1", 0, 4'b0000, 1'b0);
        chk("hold_e1", {3'b000, E1}, 4'b0001);
        apply("hold_2", 0, 4'b0000, 1'b0);
        apply("hold_rel", 0, 4'b0000, 1'b1);
        chk("hold_rel_e1", {3'b000, E1}, 4'b0000);

        // Asynchronous clear between edges, then reload from current inputs.
        apply("mid_load", 0, 4'b0001, 1'b1);
        #1 rst_n = 1'b0;
        mdl_e = '0; mdl_in = '0;
        #1 chk("mid_clr", outs(), 4'b0000);
        #1 rst_n = 1'b1;
        apply("mid_reload", 0, 4'b0001, 1'b1);
        chk("mid_reload_e1", {3'b000, E1}, 4'b0001);

        // Random run: inputs, select and enable all random.
        for (int i = 0; i < 200; i++) begin
            apply("rand", int'($urandom_range(3)), 4'($urandom), 1'($urandom));
            // Inputs wiggled mid-cycle must not reach the outputs.
            A = 1'($urandom); C = 1'($urandom); x = 1'($urandom);
            #2 chk("mid_stable", outs(), mdl_e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
